playground_core: RTL and testbench



---
 rtl/playground_core.sv | 172 +++++++++++++++++
 tb/tb_playground_core.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/playground_core.sv
// playground_core: board bring-up block. It drives six LEDs with a pattern that
// alternates between a bouncing single-LED scan and a 6-bit binary count, and it
// drives a free-running square wave on test_pin.
module playground_core #(
  parameter int unsigned STEP_DIV       = 13_500_000,
  parameter int unsigned TEST_DIV       = 1_350,
  parameter int unsigned SCAN_BOUNCES   = 2,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [5:0] led,
  output logic       test_pin
);

  localparam int unsigned LED_N  = 6;
  localparam int unsigned POS_W  = 3;
  localparam int unsigned STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned TEST_W = (TEST_DIV > 1) ? $clog2(TEST_DIV) : 1;
  localparam int unsigned BNC_W  = $clog2(SCAN_BOUNCES + 1);

  localparam logic [POS_W-1:0] POS_MIN  = POS_W'(0);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(LED_N - 1);
  localparam logic [LED_N-1:0] PAT_RST  = LED_N'(1);
  localparam logic [LED_N-1:0] CNT_LAST = {LED_N{1'b1}};
  localparam logic [LED_N-1:0] LED_RST  = LED_ACTIVE_LOW ? ~PAT_RST : PAT_RST;

  typedef enum logic {
    MODE_SCAN  = 1'b0,
    MODE_COUNT = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [TEST_W-1:0] test_cnt_q, test_cnt_d;
  logic              test_pin_q, test_pin_d;
  mode_e             mode_q, mode_d;
  dir_e              dir_q, dir_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [BNC_W-1:0]  bounce_q, bounce_d;
  logic [LED_N-1:0]  count_q, count_d;
  logic [LED_N-1:0]  pattern_q, pattern_d;
  logic [LED_N-1:0]  led_q, led_d;

  logic              step_pulse_c;
  logic              test_tgl_c;
  logic [BNC_W-1:0]  bounce_inc_c;

  // Step prescaler: wraps every STEP_DIV cycles, pulsing on the terminal count.
  always_comb begin
    step_pulse_c = (step_cnt_q == STEP_W'(STEP_DIV - 1));
    step_cnt_d   = step_pulse_c ? '0 : step_cnt_q + STEP_W'(1);
  end

  // Test prescaler: independent wrap that toggles test_pin on its terminal count.
  always_comb begin
    test_tgl_c = (test_cnt_q == TEST_W'(TEST_DIV - 1));
    test_cnt_d = test_tgl_c ? '0 : test_cnt_q + TEST_W'(1);
    test_pin_d = test_pin_q ^ test_tgl_c;
  end

  // Pattern FSM: advances one step per step pulse; the LED image follows in the same edge.
  always_comb begin
    mode_d       = mode_q;
    dir_d        = dir_q;
    pos_d        = pos_q;
    bounce_d     = bounce_q;
    count_d      = count_q;
    pattern_d    = pattern_q;
    bounce_inc_c = bounce_q + BNC_W'(1);

    if (step_pulse_c) begin
      unique case (mode_q)
        MODE_SCAN: begin
          if (pos_q > POS_MAX) begin
            // Unused position encodings restart the scan from the first LED.
            pos_d    = POS_MIN;
            dir_d    = DIR_UP;
            bounce_d = '0;
          end else if (dir_q == DIR_UP) begin
            if (pos_q == POS_MAX) begin
              pos_d = POS_MAX - POS_W'(1);
              dir_d = DIR_DOWN;
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end else begin
            if (pos_q == POS_ONE) begin
              // Landing on LED 0 completes a bounce; the last bounce hands over to COUNT.
              pos_d = POS_MIN;
              dir_d = DIR_UP;
              if (bounce_inc_c >= BNC_W'(SCAN_BOUNCES)) begin
                mode_d   = MODE_COUNT;
                bounce_d = '0;
                count_d  = '0;
              end else begin
                bounce_d = bounce_inc_c;
              end
            end else if (pos_q == POS_MIN) begin
              pos_d = POS_MIN;
              dir_d = DIR_UP;
            end else begin
              pos_d = pos_q - POS_W'(1);
            end
          end
        end
        MODE_COUNT: begin
          if (count_q == CNT_LAST) begin
            mode_d   = MODE_SCAN;
            pos_d    = POS_MIN;
            dir_d    = DIR_UP;
            bounce_d = '0;
            count_d  = '0;
          end else begin
            count_d = count_q + LED_N'(1);
          end
        end
        default: begin
          mode_d   = MODE_SCAN;
          pos_d    = POS_MIN;
          dir_d    = DIR_UP;
          bounce_d = '0;
          count_d  = '0;
        end
      endcase

      if (mode_d == MODE_COUNT) begin
        pattern_d = count_d;
      end else begin
        pattern_d = PAT_RST << pos_d;
      end
    end

    led_d = LED_ACTIVE_LOW ? ~pattern_d : pattern_d;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      step_cnt_q <= '0;
      test_cnt_q <= '0;
      test_pin_q <= 1'b0;
      mode_q     <= MODE_SCAN;
      dir_q      <= DIR_UP;
      pos_q      <= POS_MIN;
      bounce_q   <= '0;
      count_q    <= '0;
      pattern_q  <= PAT_RST;
      led_q      <= LED_RST;
    end else begin
      step_cnt_q <= step_cnt_d;
      test_cnt_q <= test_cnt_d;
      test_pin_q <= test_pin_d;
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      pos_q      <= pos_d;
      bounce_q   <= bounce_d;
      count_q    <= count_d;
      pattern_q  <= pattern_d;
      led_q      <= led_d;
    end
  end

  assign led      = led_q;
  assign test_pin = test_pin_q;

endmodule

// File: tb/tb_playground_core.sv
// tb_playground_core: randomized reset stimulus on two differently parameterised
// instances; expected LED/test_pin values come from a cycle-count model pushed
// into a scoreboard queue and checked by an independent monitor.
module tb_playground_core;

  localparam int unsigned A_STEP = 2;
  localparam int unsigned A_TEST = 3;
  localparam int unsigned A_BNC  = 2;
  localparam int unsigned B_STEP = 3;
  localparam int unsigned B_TEST = 5;
  localparam int unsigned B_BNC  = 1;
  localparam int          N_CYC  = 4000;

  typedef struct packed {
    logic [5:0] led_a;
    logic       tp_a;
    logic [5:0] led_b;
    logic       tp_b;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [5:0] led_a, led_b;
  logic       tp_a, tp_b;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;
  int   cyc;

  playground_core #(
    .STEP_DIV(A_STEP), .TEST_DIV(A_TEST), .SCAN_BOUNCES(A_BNC), .LED_ACTIVE_LOW(1'b1)
  ) u_dut_a (
    .clk(clk), .reset(reset), .led(led_a), .test_pin(tp_a)
  );

  playground_core #(
    .STEP_DIV(B_STEP), .TEST_DIV(B_TEST), .SCAN_BOUNCES(B_BNC), .LED_ACTIVE_LOW(1'b0)
  ) u_dut_b (
    .clk(clk), .reset(reset), .led(led_b), .test_pin(tp_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs after t edges with reset released: one pattern step per
  // sd cycles, a full cycle being 10*nb scan steps followed by 64 count steps.
  function automatic logic [6:0] model(input int unsigned t, input int unsigned sd,
                                       input int unsigned td, input int unsigned nb,
                                       input bit al);
    int unsigned steps, period, ph, p, pos;
    logic [5:0]  pat;
    logic        tp;
    steps  = t / sd;
    period = 10 * nb + 64;
    ph     = steps % period;
    if (ph < 10 * nb) begin
      p   = ph % 10;
      pos = (p <= 5) ? p : 10 - p;
      pat = 6'(1 << pos);
    end else begin
      pat = 6'(ph - 10 * nb);
    end
    tp = 1'((t / td) % 2);
    return {al ? ~pat : pat, tp};
  endfunction

  // Stimulus + model: push expectations after each edge, then pick next reset value.
  initial begin
    int unsigned t;
    bit          r;
    int          hold;
    bit          forced;
    logic [6:0]  ma, mb;
    exp_t        e;
    reset    = 1'b0;
    r        = 1'b0;
    t        = 0;
    hold     = 0;
    forced   = 1'b0;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    for (int i = 0; i < N_CYC; i++) begin
      @(posedge clk);
      if (!r) t = 0;
      else    t = t + 1;
      ma = model(t, A_STEP, A_TEST, A_BNC, 1'b1);
      mb = model(t, B_STEP, B_TEST, B_BNC, 1'b0);
      e.led_a = ma[6:1];
      e.tp_a  = ma[0];
      e.led_b = mb[6:1];
      e.tp_b  = mb[0];
      exp_q.push_back(e);
      #1;
      cyc = i;
      if (i < 10) begin
        r = 1'b0;
      end else if (hold > 0) begin
        r    = 1'b0;
        hold = hold - 1;
      end else if (!forced && i > 1500 && ((t / A_STEP) % (10 * A_BNC + 64)) >= 40) begin
        // One-cycle reset while instance A is displaying the binary count.
        r      = 1'b0;
        forced = 1'b1;
      end else if ($urandom_range(0, 499) == 0) begin
        r    = 1'b0;
        hold = int'($urandom_range(0, 2));
      end else begin
        r = 1'b1;
      end
      reset = r;
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Monitor: outputs are presented every cycle; compare mid-cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_empty: cycle %0d no expectation queued", cyc);
      end else begin
        e = exp_q.pop_front();
        n_checks += 3;
        if (led_a !== e.led_a) begin
          n_errors++;
          $display("FAIL led_a: cycle %0d got %b expected %b", cyc, led_a, e.led_a);
        end
        if (tp_a !== e.tp_a) begin
          n_errors++;
          $display("FAIL test_pin_a: cycle %0d got %b expected %b", cyc, tp_a, e.tp_a);
        end
        if (led_b !== e.led_b) begin
          n_errors++;
          $display("FAIL led_b: cycle %0d got %b expected %b", cyc, led_b, e.led_b);
        end
        if (tp_b !== e.tp_b) begin
          n_errors++;
          $display("FAIL test_pin_b: cycle %0d got %b expected %b", cyc, tp_b, e.tp_b);
        end
      end
    end
  end

endmodule
